console_writer: RTL

Command initiator for the character display's `cmd`/`data`/`ready` port. It accepts a stream of tokens from upstream logic: signed 32-bit numbers, newlines and blank slots. It keeps a text cursor, converts each token into display commands (NUMBER, POS CLEAR, SCROLL) and issues them one at a time under the display's ready handshake. It sits between compute logic and the display, on the display's `clk` domain.

---
 rtl/console_writer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/console_writer.sv
// console_writer
//   Turns a stream of tokens (numbers, newlines, blank slots) into display
//   commands (NUMBER, POS CLEAR, SCROLL), tracking a text cursor and issuing
//   one command at a time under the display's ready handshake.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   token handshake (in_ready = token FIFO not full)
//     in_kind, in_value   token: 0 number, 1 newline, 2 blank, 3 ignored
//     cmd, data           display command and payload {x, y, value}
//     ready               display idle and accepting a command
//     busy                FIFO non-empty or command sequencer active
//     cmd_count           non-NOP commands issued, wraps modulo 2^16
module console_writer #(
  parameter int COLS  = 10,
  parameter int ROWS  = 45,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  in_kind,
  input  logic [31:0] in_value,
  output logic        in_ready,
  output logic [3:0]  cmd,
  output logic [47:0] data,
  input  logic        ready,
  output logic        busy,
  output logic [15:0] cmd_count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [7:0]  COLS_L   = 8'(COLS);
  localparam logic [7:0]  ROW_LAST = 8'(ROWS - 1);

  localparam logic [3:0] CMD_NOP    = 4'd0;
  localparam logic [3:0] CMD_SCROLL = 4'd1;
  localparam logic [3:0] CMD_POSCLR = 4'd2;
  localparam logic [3:0] CMD_NUMBER = 4'd3;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_DRIVE, S_ADVANCE} state_t;

  // ---------------- token FIFO ----------------
  logic [33:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;
  logic [33:0] head;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_kind, in_value};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // ---------------- command sequencer ----------------
  state_t      state, state_nxt;
  logic [7:0]  col, col_nxt, row, row_nxt, col_inc;
  logic [3:0]  pend_cmd, pend_cmd_nxt, cmd_nxt;
  logic [47:0] pend_data, pend_data_nxt, data_nxt;
  logic [15:0] count_nxt;

  assign col_inc = col + 8'd1;
  assign busy    = !empty || (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      pend_cmd  <= CMD_NOP;
      pend_data <= '0;
      cmd       <= CMD_NOP;
      data      <= '0;
      cmd_count <= '0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      pend_cmd  <= pend_cmd_nxt;
      pend_data <= pend_data_nxt;
      cmd       <= cmd_nxt;
      data      <= data_nxt;
      cmd_count <= count_nxt;
    end
  end

  // cmd/data are registered: they default to NOP each cycle, so a command
  // launched on one edge is withdrawn on the next (the DRIVE cycle).
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    col_nxt       = col;
    row_nxt       = row;
    pend_cmd_nxt  = pend_cmd;
    pend_data_nxt = pend_data;
    cmd_nxt       = CMD_NOP;
    data_nxt      = '0;
    count_nxt     = cmd_count;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          case (head[33:32])
            2'd0: begin
              pend_cmd_nxt  = CMD_NUMBER;
              pend_data_nxt = {col, row, head[31:0]};
              state_nxt     = S_LAUNCH;
            end
            2'd1: begin
              col_nxt   = '0;
              state_nxt = S_ADVANCE;
            end
            2'd2: begin
              pend_cmd_nxt  = CMD_POSCLR;
              pend_data_nxt = {col, row, 32'd0};
              state_nxt     = S_LAUNCH;
            end
            default: ;
          endcase
        end
      end
      S_LAUNCH: begin
        if (ready) begin
          cmd_nxt   = pend_cmd;
          data_nxt  = pend_data;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        count_nxt = cmd_count + 16'd1;
        if (pend_cmd == CMD_SCROLL) begin
          state_nxt = S_IDLE;
        end else if (col_inc == COLS_L) begin
          col_nxt   = '0;
          state_nxt = S_ADVANCE;
        end else begin
          col_nxt   = col_inc;
          state_nxt = S_IDLE;
        end
      end
      S_ADVANCE: begin
        if (row < ROW_LAST) begin
          row_nxt   = row + 8'd1;
          state_nxt = S_IDLE;
        end else begin
          // Bottom row: scroll the display instead; the cursor row stays put.
          pend_cmd_nxt  = CMD_SCROLL;
          pend_data_nxt = '0;
          state_nxt     = S_LAUNCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
